reg_bank_arbiter: RTL and testbench
===================================

REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have ports req0/req1, input, 1 each, access request from requester 0/1.
REQ-004 SHALL have ports we0/we1, input, 1 each, 1 = write, 0 = read.
REQ-005 SHALL have ports addr0/addr1, input, 2 each, register index 0..3.
REQ-006 SHALL have ports wdata0/wdata1, input, 8 each, write data.
REQ-007 SHALL have ports gnt0/gnt1, output, 1 each, one-cycle grant pulse.
REQ-008 SHALL have port rdata, output, 8, read data, valid only while rvalid=1.
REQ-009 SHALL have port rvalid, output, 1, one-cycle read-data-valid pulse.
REQ-010 SHALL have port rid, output, 1, requester owning the current rdata.
REQ-011 SHALL have port busy, output, 1, high while a transaction is in progress.

Function
REQ-012 SHALL contain a bank of 4 x 8-bit edge-triggered registers shared by both requesters.
REQ-013 SHALL implement FSM states IDLE, ACCESS, DONE; IDLE->ACCESS when req0|req1 at the edge; ACCESS->DONE unconditionally; DONE->IDLE unconditionally.
REQ-014 SHALL, on the IDLE->ACCESS edge, latch winner, its we, addr and wdata; later changes on the inputs have no effect on the transaction.
REQ-015 SHALL assert gnt of the winner, and only that gnt, for exactly the ACCESS cycle.
REQ-016 SHALL, for a write, update bank[addr] with the latched wdata at the ACCESS->DONE edge.
REQ-017 SHALL, for a read, drive rdata = bank[addr], rvalid = 1, rid = winner during the DONE cycle only; rvalid = 0 for writes.
REQ-018 SHALL hold rdata at its last value whenever rvalid = 0.
REQ-019 SHALL assert busy in ACCESS and DONE; busy = 0 in IDLE.
REQ-020 SHALL sample requests only in IDLE; requests asserted during ACCESS/DONE are held off, not lost, provided req stays high.
REQ-021 Requester SHALL deassert req in the cycle after its gnt; a req still high in IDLE starts a new transaction.
REQ-022 SHALL give a throughput of one transaction per 3 cycles; read latency from the winning IDLE edge to rvalid is 2 cycles.
REQ-023 SHALL keep last_winner (1 bit), updated to winner on every IDLE->ACCESS edge.
REQ-024 A read in the transaction following a write to the same address SHALL return the newly written value.

Reset
REQ-025 SHALL, on rst=1 and independent of clk, force state IDLE, all bank registers 8'h00, gnt0 = gnt1 = 0, rvalid = 0, rdata = 8'h00, rid = 0, busy = 0, last_winner = 1.
REQ-026 SHALL abandon any in-flight transaction on reset; a write in ACCESS when rst rises SHALL NOT reach the bank.
REQ-027 SHALL begin arbitration on the first rising clk edge after rst falls.

Configuration
REQ-028 Macro ARB_ROUND_ROBIN_EN defined: one requester alone wins; with both requesting, winner = ~last_winner (requester 0 first after reset).
REQ-029 ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins a tie; last_winner is still kept but not used.

Verification
REQ-030 Reset, then req0 write addr=2 wdata=8'hA5 -> gnt0 in cycle 2, busy in cycles 2-3; req0 read addr=2 -> rvalid=1, rdata=8'hA5, rid=0 two cycles after the winning edge.
REQ-031 Both req held high, both reads, ARB_ROUND_ROBIN_EN defined -> grants in order gnt0, gnt1, gnt0, gnt1, spaced 3 cycles apart; undefined -> gnt0 every time, gnt1 never.
REQ-032 req1 asserted during req0's ACCESS cycle -> gnt1 no earlier than the cycle after DONE; req1 transaction completes correctly.
REQ-033 wdata0 changed from 8'h11 to 8'hFF in the ACCESS cycle of a write of 8'h11 to addr 0 -> later read of addr 0 returns 8'h11.
REQ-034 rst pulsed in the middle of ACCESS of a write of 8'h3C to addr 1 -> all outputs 0 immediately, state IDLE, later read of addr 1 returns 8'h00.
REQ-035 Writes of 8'h01..8'h04 to addr 0..3, then reads of all four -> rdata 8'h01..8'h04 in order, rvalid exactly 4 single-cycle pulses.

Source files
------------

// File: rtl/reg_bank_arbiter.sv
// Two-requester arbiter in front of a shared 4 x 8-bit register bank; 3-cycle IDLE/ACCESS/DONE transactions.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed priority to requester 0.
module reg_bank_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic [1:0] addr0,
    input  logic [1:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       gnt0,
    output logic       gnt1,
    output logic [7:0] rdata,
    output logic       rvalid,
    output logic       rid,
    output logic       busy
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]      state_q, state_d;
    logic            win_q, win_d;
    logic            we_q, we_d;
    logic [1:0]      addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic            last_winner_q, last_winner_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            rid_q, rid_d;
    logic [3:0][7:0] bank_q, bank_d;
    logic            winner;

    // winner only matters when at least one request is up
    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        winner = (req0 && req1) ? ~last_winner_q : req1;
`else
        winner = ~req0 & req1;
`endif
    end

    always_comb begin
        state_d       = state_q;
        win_d         = win_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        last_winner_d = last_winner_q;
        rdata_d       = rdata_q;
        rid_d         = rid_q;
        bank_d        = bank_q;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    state_d       = S_ACCESS;
                    win_d         = winner;
                    we_d          = winner ? we1 : we0;
                    addr_d        = winner ? addr1 : addr0;
                    wdata_d       = winner ? wdata1 : wdata0;
                    last_winner_d = winner;
                end
            end
            S_ACCESS: begin
                state_d = S_DONE;
                // read data is captured here so it is stable for the whole DONE cycle and held after
                if (we_q) begin
                    bank_d[addr_q] = wdata_q;
                end else begin
                    rdata_d = bank_q[addr_q];
                    rid_d   = win_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            win_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= 2'd0;
            wdata_q       <= 8'h00;
            last_winner_q <= 1'b1;
            rdata_q       <= 8'h00;
            rid_q         <= 1'b0;
            bank_q        <= '0;
        end else begin
            state_q       <= state_d;
            win_q         <= win_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            last_winner_q <= last_winner_d;
            rdata_q       <= rdata_d;
            rid_q         <= rid_d;
            bank_q        <= bank_d;
        end
    end

    assign gnt0   = (state_q == S_ACCESS) && !win_q;
    assign gnt1   = (state_q == S_ACCESS) && win_q;
    assign rvalid = (state_q == S_DONE) && !we_q;
    assign busy   = (state_q != S_IDLE);
    assign rdata  = rdata_q;
    assign rid    = rid_q;
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Vector-table bench for reg_bank_arbiter with a read-data scoreboard queue.
module tb_reg_bank_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, we0, we1;
    logic [1:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, rvalid, rid, busy;
    logic [7:0] rdata;

    reg_bank_arbiter dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rdata(rdata), .rvalid(rvalid), .rid(rid), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       who;
        bit       we;
        bit [1:0] addr;
        bit [7:0] wd;
        bit [7:0] exp_rd;
    } vec_t;

    typedef struct {
        bit       rid;
        bit [7:0] d;
    } rd_t;

    vec_t vt[14];
    rd_t  sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rv_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // scoreboard: every rvalid cycle must match the oldest expected read
    always @(negedge clk) begin
        if (rvalid) begin
            rv_cnt++;
            if (sb.size() == 0) begin
                chk("rvalid_unexpected", 1, 0);
            end else begin
                rd_t e;
                e = sb.pop_front();
                chk("rdata", rdata, e.d);
                chk("rid", rid, e.rid);
            end
        end
    end

    task automatic drive(input int who, input bit we, input bit [1:0] addr, input bit [7:0] wd);
        if (who == 0) begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd; end
        else          begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd; end
    endtask

    task automatic run_txn(input int who, input bit we, input bit [1:0] addr,
                           input bit [7:0] wd, input bit [7:0] exp_rd);
        rd_t e;
        @(negedge clk);
        drive(who, we, addr, wd);
        if (!we) begin e.rid = who[0]; e.d = exp_rd; sb.push_back(e); end
        @(posedge clk); #1;
        chk("gnt0", gnt0, who == 0);
        chk("gnt1", gnt1, who == 1);
        chk("busy_access", busy, 1);
        // drop request and scramble inputs: the transaction must use latched values
        req0 = 1'b0; req1 = 1'b0; wdata0 = 8'hFF; wdata1 = 8'hFF; addr0 = ~addr; addr1 = ~addr;
        we0 = ~we; we1 = ~we;
        @(posedge clk); #1;
        chk("busy_done", busy, 1);
        chk("rvalid_done", rvalid, !we);
        @(posedge clk); #1;
        chk("busy_idle", busy, 0);
        chk("rvalid_idle", rvalid, 0);
        if (!we) chk("rdata_hold", rdata, exp_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rd_t e;
        int  rd_exp;
        int  rv0;
        bit  exp_w;

        vt[0]  = '{0, 1'b1, 2'd2, 8'hA5, 8'h00};
        vt[1]  = '{0, 1'b0, 2'd2, 8'h00, 8'hA5};
        vt[2]  = '{0, 1'b1, 2'd0, 8'h11, 8'h00};
        vt[3]  = '{1, 1'b0, 2'd0, 8'h00, 8'h11};
        for (int i = 0; i < 4; i++) vt[4+i] = '{i % 2, 1'b1, i[1:0], 8'(i + 1), 8'h00};
        for (int i = 0; i < 4; i++) vt[8+i] = '{(i + 1) % 2, 1'b0, i[1:0], 8'h00, 8'(i + 1)};
        vt[12] = '{1, 1'b1, 2'd3, 8'h5A, 8'h00};
        vt[13] = '{0, 1'b0, 2'd3, 8'h00, 8'h5A};

        rst = 1'b1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        #12;
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rid", rid, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk); rst = 1'b0;

        rv0 = rv_cnt; rd_exp = 0;
        for (int i = 0; i < 14; i++) begin
            run_txn(vt[i].who, vt[i].we, vt[i].addr, vt[i].wd, vt[i].exp_rd);
            if (!vt[i].we) rd_exp++;
        end
        chk("rvalid_pulses", rv_cnt - rv0, rd_exp);

        // request from 1 arriving mid-transaction is held off until the next IDLE sample
        @(negedge clk);
        drive(0, 1'b1, 2'd1, 8'hC3);
        @(posedge clk); #1;
        chk("hold_gnt0", gnt0, 1);
        req0 = 1'b0;
        drive(1, 1'b0, 2'd1, 8'h00);
        e.rid = 1'b1; e.d = 8'hC3; sb.push_back(e);
        @(posedge clk); #1;
        chk("hold_gnt1_done", gnt1, 0);
        @(posedge clk); #1;
        chk("hold_gnt1_idle", gnt1, 0);
        chk("hold_busy_idle", busy, 0);
        @(posedge clk); #1;
        chk("hold_gnt1_access", gnt1, 1);
        req1 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("hold_busy_end", busy, 0);

        // reset in the middle of a write's ACCESS cycle
        @(negedge clk);
        drive(0, 1'b1, 2'd1, 8'h3C);
        @(posedge clk); #1;
        chk("rstmid_gnt0", gnt0, 1);
        req0 = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rstmid_gnt0_low", gnt0, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_rvalid", rvalid, 0);
        chk("rstmid_rdata", rdata, 0);
        chk("rstmid_rid", rid, 0);
        @(negedge clk); rst = 1'b0;
        run_txn(1, 1'b0, 2'd1, 8'h00, 8'h00);

        // both requesters held high, reads, starting from reset state
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 2'd0; addr1 = 2'd3;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_w = k[0];
`else
            exp_w = 1'b0;
`endif
            e.rid = exp_w; e.d = 8'h00; sb.push_back(e);
            @(posedge clk); #1;
            chk("tie_gnt0", gnt0, !exp_w);
            chk("tie_gnt1", gnt1, exp_w);
            @(posedge clk); #1;
            chk("tie_gnt_off", gnt0 | gnt1, 0);
            @(posedge clk); #1;
            if (k == 3) begin req0 = 1'b0; req1 = 1'b0; end
        end
        repeat (3) @(posedge clk);
        #1;
        chk("busy_final", busy, 0);
        chk("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
